sparce_sasa_table_assoc: RTL and testbench



---
 rtl/sparce_pkg.sv | 23 ++
 rtl/sparce_sasa_table_assoc_if.sv | 11 +
 rtl/sparce_sasa_lru.sv | 24 ++
 rtl/sparce_sasa_table_assoc.sv | 133 +++++++++++++
 tb/tb_sparce_sasa_table_assoc.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sparce_pkg.sv
// sparce_pkg: shared SPARCE types, SASA entry/data layouts, bus offsets and flush FSM states
package sparce_pkg;
  typedef enum logic {SASA_COND_OR = 1'b0, SASA_COND_AND = 1'b1} sasa_cond_t;
  typedef enum logic {SASA_IDLE = 1'b0, SASA_FLUSH = 1'b1} sasa_state_t;
  typedef struct packed {
    logic valid;
    logic [15:0] tag;
    logic [4:0] rs1;
    logic [4:0] rs2;
    sasa_cond_t cond;
    logic [4:0] skip;
  } sasa_entry_t;
  typedef struct packed {
    logic [15:0] key;
    logic [4:0] rs1;
    logic [4:0] rs2;
    sasa_cond_t cond;
    logic [4:0] skip;
  } sasa_wdata_t;
  localparam logic [31:0] SASA_OFS_ENTRY = 32'd0;
  localparam logic [31:0] SASA_OFS_CFG = 32'd4;
  localparam logic [31:0] SASA_OFS_CMD = 32'd8;
endpackage

// File: rtl/sparce_sasa_table_assoc_if.sv
// sparce_sasa_table_assoc_if: memory-mapped SASA write port
// master drives enable/wen/addr/data and observes busy; slave is the table side.
interface sparce_sasa_table_assoc_if;
  logic sasa_enable;
  logic sasa_wen;
  logic [31:0] sasa_addr;
  logic [31:0] sasa_data;
  logic sasa_busy;
  modport master(output sasa_enable, sasa_wen, sasa_addr, sasa_data, input sasa_busy);
  modport slave(input sasa_enable, sasa_wen, sasa_addr, sasa_data, output sasa_busy);
endinterface

// File: rtl/sparce_sasa_lru.sv
// sparce_sasa_lru: true-LRU age vector for one set
// Ports: CLK, RST (sync, active-high); promote/way move a way to age 0 and age the younger ones;
//        reset_ages restores age i to way i; ages is the age vector, victim the oldest way.
module sparce_sasa_lru #(
  parameter int WAYS = 2,
  parameter int AGE_W = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic promote,
  input  logic [AGE_W-1:0] way,
  input  logic reset_ages,
  output logic [WAYS-1:0][AGE_W-1:0] ages,
  output logic [AGE_W-1:0] victim
);
  always_ff @(posedge CLK)
    for (int i = 0; i < WAYS; i++)
      if (RST || reset_ages) ages[i] <= AGE_W'(i);
      else if (promote) ages[i] <= (AGE_W'(i) == way) ? '0 : (ages[i] < ages[way]) ? ages[i] + AGE_W'(1) : ages[i];
  always_comb begin
    victim = '0;
    for (int i = 0; i < WAYS; i++) if (ages[i] == AGE_W'(WAYS - 1)) victim = AGE_W'(i);
  end
endmodule

// File: rtl/sparce_sasa_table_assoc.sv
// sparce_sasa_table_assoc: N-way set-associative SASA skip-ahead table with flush walk
// Ports: CLK, RST (sync, active-high); pc lookup key; bus = SASA write port (entry +0, config +4,
//        command +8, busy); sasa_rs1/sasa_rs2/condition/insts_to_skip = hit entry fields (0/OR on miss);
//        preceding_pc = pc; valid = skip permitted.
// Optional: SPARCE_SASA_STATS_EN adds saturating lookup_hits/skips_taken counters (cmd bit 2 clears).
module sparce_sasa_table_assoc import sparce_pkg::*; #(
  parameter int SASA_ENTRIES = 16,
  parameter int SASA_WAYS = 2,
  parameter logic [31:0] SASA_ADDR = 32'h9000_0000
) (
  input  logic CLK,
  input  logic RST,
  input  logic [31:0] pc,
  sparce_sasa_table_assoc_if.slave bus,
  output logic [4:0] sasa_rs1,
  output logic [4:0] sasa_rs2,
  output sasa_cond_t condition,
  output logic [4:0] insts_to_skip,
  output logic [31:0] preceding_pc,
  output logic valid
`ifdef SPARCE_SASA_STATS_EN
  ,
  output logic [31:0] lookup_hits,
  output logic [31:0] skips_taken
`endif
);
  localparam int SETS = SASA_ENTRIES / SASA_WAYS;
  localparam int IDX_W = SETS > 1 ? $clog2(SETS) : 0;
  localparam int TAG_W = 16 - IDX_W;
  localparam int AGE_W = SASA_WAYS > 1 ? $clog2(SASA_WAYS) : 1;
  localparam int SW = IDX_W > 0 ? IDX_W : 1;
  function automatic logic [SW-1:0] set_of(logic [15:0] k);
    return SETS > 1 ? k[SW-1:0] : '0;
  endfunction
  function automatic logic [15:0] tag_of(logic [15:0] k);
    return 16'(k[15:16-TAG_W]);
  endfunction
  sasa_state_t state;
  logic busy, cfg;
  logic [SW-1:0] cnt;
  sasa_entry_t ent [SETS][SASA_WAYS];
  logic [SETS-1:0][SASA_WAYS-1:0][AGE_W-1:0] ages;
  logic [SETS-1:0][AGE_W-1:0] victim;
  sasa_wdata_t wd;
  sasa_entry_t e_hit;
  logic [SW-1:0] set_l, set_w;
  logic [15:0] tag_l, tag_w;
  logic [AGE_W-1:0] hway, wway;
  logic hit, idle, acc, wr_ent, wr_cfg, wr_cmd, do_flush, do_inv, prom_hit;
  assign wd = bus.sasa_data;
  assign set_l = set_of(pc[17:2]);
  assign tag_l = tag_of(pc[17:2]);
  assign set_w = set_of(wd.key);
  assign tag_w = tag_of(wd.key);
  // Descending scan so the lowest matching way wins if duplicates ever exist.
  always_comb begin
    hit = 1'b0;
    hway = '0;
    for (int w = SASA_WAYS - 1; w >= 0; w--)
      if (ent[set_l][w].valid && ent[set_l][w].tag == tag_l) begin
        hit = 1'b1;
        hway = AGE_W'(w);
      end
  end
  // Later loop overrides earlier: matching tag beats lowest invalid beats LRU victim.
  always_comb begin
    wway = victim[set_w];
    for (int w = SASA_WAYS - 1; w >= 0; w--) if (!ent[set_w][w].valid) wway = AGE_W'(w);
    for (int w = SASA_WAYS - 1; w >= 0; w--) if (ent[set_w][w].valid && ent[set_w][w].tag == tag_w) wway = AGE_W'(w);
  end
  assign e_hit = ent[set_l][hway];
  assign sasa_rs1 = hit ? e_hit.rs1 : '0;
  assign sasa_rs2 = hit ? e_hit.rs2 : '0;
  assign insts_to_skip = hit ? e_hit.skip : '0;
  assign condition = hit ? e_hit.cond : SASA_COND_OR;
  assign preceding_pc = pc;
  assign idle = state == SASA_IDLE;
  assign valid = hit && !cfg && pc[31:18] == '0 && idle;
  assign bus.sasa_busy = busy;
  assign acc = bus.sasa_enable && bus.sasa_wen;
  assign wr_ent = acc && idle && bus.sasa_addr == SASA_ADDR + SASA_OFS_ENTRY;
  assign wr_cfg = acc && bus.sasa_addr == SASA_ADDR + SASA_OFS_CFG;
  assign wr_cmd = acc && idle && bus.sasa_addr == SASA_ADDR + SASA_OFS_CMD;
  assign do_flush = wr_cmd && bus.sasa_data[0];
  assign do_inv = wr_cmd && bus.sasa_data[1] && !bus.sasa_data[0];
  assign prom_hit = hit && idle && !wr_ent && !wr_cmd;
  for (genvar s = 0; s < SETS; s++) begin : g_set
    sparce_sasa_lru #(.WAYS(SASA_WAYS), .AGE_W(AGE_W)) u_lru (
      .CLK(CLK),
      .RST(RST),
      .promote((wr_ent && set_w == SW'(s)) || (prom_hit && set_l == SW'(s))),
      .way(wr_ent ? wway : hway),
      .reset_ages(state == SASA_FLUSH && cnt == SW'(s)),
      .ages(ages[s]),
      .victim(victim[s])
    );
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state <= SASA_IDLE;
      busy <= 1'b0;
      cnt <= '0;
      cfg <= 1'b0;
      for (int s = 0; s < SETS; s++) for (int w = 0; w < SASA_WAYS; w++) ent[s][w] <= '0;
    end else begin
      if (wr_cfg) cfg <= bus.sasa_data[0];
      if (do_flush) begin
        state <= SASA_FLUSH;
        busy <= 1'b1;
        cnt <= '0;
      end else if (state == SASA_FLUSH) begin
        for (int w = 0; w < SASA_WAYS; w++) ent[cnt][w].valid <= 1'b0;
        if (cnt == SW'(SETS - 1)) begin
          state <= SASA_IDLE;
          busy <= 1'b0;
        end else cnt <= cnt + SW'(1);
      end
      if (wr_ent) ent[set_w][wway] <= '{valid: 1'b1, tag: tag_w, rs1: wd.rs1, rs2: wd.rs2, cond: wd.cond, skip: wd.skip};
      if (do_inv)
        for (int w = 0; w < SASA_WAYS; w++)
          if (ent[set_w][w].valid && ent[set_w][w].tag == tag_w) ent[set_w][w].valid <= 1'b0;
    end
`ifdef SPARCE_SASA_STATS_EN
  always_ff @(posedge CLK)
    if (RST || (wr_cmd && bus.sasa_data[2])) begin
      lookup_hits <= '0;
      skips_taken <= '0;
    end else begin
      if (hit && ~&lookup_hits) lookup_hits <= lookup_hits + 32'd1;
      if (valid && ~&skips_taken) skips_taken <= skips_taken + 32'd1;
    end
`endif
endmodule

// File: tb/tb_sparce_sasa_table_assoc.sv
// tb_sparce_sasa_table_assoc: directed + random bench against a recency-list model of the SASA table
module tb_sparce_sasa_table_assoc;
  import sparce_pkg::*;
  localparam int W = 2, S = 8;
  localparam logic [31:0] ADDR = 32'h9000_0000, IDLE = 32'h0003_FFFC;
  logic CLK = 1'b0, RST;
  logic [31:0] pc, ppc;
  logic [4:0] rs1, rs2, skip;
  sasa_cond_t cond;
  logic vld;
  int n_cmp = 0, n_err = 0;
  sparce_sasa_table_assoc_if bus_if();
`ifdef SPARCE_SASA_STATS_EN
  logic [31:0] hits, skips, mh, ms;
`endif
  sparce_sasa_table_assoc dut (
    .CLK(CLK),
    .RST(RST),
    .pc(pc),
    .bus(bus_if),
    .sasa_rs1(rs1),
    .sasa_rs2(rs2),
    .condition(cond),
    .insts_to_skip(skip),
    .preceding_pc(ppc),
`ifdef SPARCE_SASA_STATS_EN
    .lookup_hits(hits),
    .skips_taken(skips),
`endif
    .valid(vld)
  );
  always #5 CLK = ~CLK;
  // Model: per-set valid/key/data arrays and a recency list of way numbers, most recent first.
  bit mv [S][W];
  logic [15:0] mk [S][W];
  logic [15:0] md [S][W];
  int ord [S][$];
  bit mcfg, mfl, live = 1'b0;
  int mcnt;
  function automatic int find(logic [15:0] k);
    for (int w = 0; w < W; w++) if (mv[k % S][w] && mk[k % S][w] == k) return w;
    return -1;
  endfunction
  function automatic void touch(int s, int w);
    for (int i = 0; i < ord[s].size(); i++) if (ord[s][i] == w) begin ord[s].delete(i); break; end
    ord[s].push_front(w);
  endfunction
  function automatic void clear_set(int s);
    ord[s].delete();
    for (int w = 0; w < W; w++) begin mv[s][w] = 1'b0; ord[s].push_back(w); end
  endfunction
  always @(posedge CLK) begin : model
    logic [15:0] k, dk;
    logic [31:0] d;
    int s, w, hw;
    bit acc, we, wc, ev;
    k = pc[17:2];
    hw = find(k);
    ev = hw >= 0 && !mcfg && pc[31:18] == 0 && !mfl;
    d = bus_if.sasa_data;
    if (RST) begin
      for (int i = 0; i < S; i++) begin
        clear_set(i);
        for (int j = 0; j < W; j++) begin mk[i][j] = '0; md[i][j] = '0; end
      end
      mcfg = 1'b0; mfl = 1'b0; mcnt = 0; live = 1'b1;
`ifdef SPARCE_SASA_STATS_EN
      mh = '0; ms = '0;
`endif
    end else begin
      acc = bus_if.sasa_enable && bus_if.sasa_wen;
      dk = d[31:16];
      s = dk % S;
      we = acc && !mfl && bus_if.sasa_addr == ADDR;
      wc = acc && !mfl && bus_if.sasa_addr == ADDR + 8;
      if (acc && bus_if.sasa_addr == ADDR + 4) mcfg = d[0];
`ifdef SPARCE_SASA_STATS_EN
      if (wc && d[2]) begin mh = '0; ms = '0; end
      else begin
        if (hw >= 0 && mh != '1) mh++;
        if (ev && ms != '1) ms++;
      end
`endif
      w = find(dk);
      if (mfl) begin
        clear_set(mcnt);
        if (mcnt == S - 1) mfl = 1'b0; else mcnt++;
      end else if (wc && d[0]) begin mfl = 1'b1; mcnt = 0; end
      else if (wc && d[1] && w >= 0) mv[s][w] = 1'b0;
      if (we) begin
        if (w < 0) begin
          w = ord[s][W-1];
          for (int i = W - 1; i >= 0; i--) if (!mv[s][i]) w = i;
        end
        mv[s][w] = 1'b1; mk[s][w] = dk; md[s][w] = d[15:0];
        touch(s, w);
      end else if (hw >= 0 && !mfl && !wc) touch(k % S, hw);
    end
  end
  always @(negedge CLK) if (live) begin : cmp
    int w;
    logic [15:0] d;
    logic [49:0] ex, ac;
    w = find(pc[17:2]);
    d = '0;
    if (w >= 0) d = md[pc[17:2] % S][w];
    ex = {mfl, w >= 0 && !mcfg && pc[31:18] == 0 && !mfl, d[15:11], d[10:6], d[5], d[4:0], pc};
    ac = {bus_if.sasa_busy, vld, rs1, rs2, logic'(cond), skip, ppc};
    n_cmp++;
    if (ac !== ex) begin n_err++; $display("FAIL cycle_cmp t=%0t: dut %h model %h", $time, ac, ex); end
`ifdef SPARCE_SASA_STATS_EN
    n_cmp++;
    if ({hits, skips} !== {mh, ms}) begin n_err++; $display("FAIL stats_cmp t=%0t: dut %h/%h model %h/%h", $time, hits, skips, mh, ms); end
`endif
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin n_err++; $display("FAIL %s: got %0h expected %0h", nm, act, exp); end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask
  task automatic look(logic [31:0] p);
    cyc();
    pc = p;
    #1;
  endtask
  task automatic wr(logic [31:0] a, logic [31:0] d);
    pc = IDLE;
    bus_if.sasa_enable = 1'b1; bus_if.sasa_wen = 1'b1; bus_if.sasa_addr = a; bus_if.sasa_data = d;
    cyc();
    bus_if.sasa_enable = 1'b0; bus_if.sasa_wen = 1'b0;
  endtask
  task automatic flush();
    int n = 0;
    wr(ADDR + 8, 32'h1);
    while (bus_if.sasa_busy && n < 40) begin cyc(); n++; end
    chk("flush_len", n, 8);
  endtask
  initial begin
    int n;
    RST = 1'b1; pc = IDLE;
    bus_if.sasa_enable = 1'b0; bus_if.sasa_wen = 1'b0; bus_if.sasa_addr = '0; bus_if.sasa_data = '0;
    cyc(); cyc();
    RST = 1'b0;
    look(IDLE); chk("rst_busy", 32'(bus_if.sasa_busy), 0);
    look(32'h40); chk("rst_valid", 32'(vld), 0); chk("rst_rs1", 32'(rs1), 0);
    wr(ADDR, 32'h0010_8845);
    look(32'h40);
    chk("hit_valid", 32'(vld), 1); chk("hit_rs1", 32'(rs1), 17); chk("hit_rs2", 32'(rs2), 1);
    chk("hit_skip", 32'(skip), 5); chk("hit_cond", 32'(cond), 0); chk("hit_ppc", ppc, 32'h40);
    look(32'h44); chk("miss_valid", 32'(vld), 0);
    wr(ADDR + 8, 32'h1);
    wr(ADDR, 32'h0003_0001);
    n = 1;
    while (bus_if.sasa_busy && n < 20) begin cyc(); n++; end
    chk("busy_len", n, 8);
    look(32'h0C); chk("drop_valid", 32'(vld), 0); chk("drop_skip", 32'(skip), 0);
    look(32'h40); chk("flush_miss", 32'(vld), 0);
    wr(ADDR, 32'h0000_0800); wr(ADDR, 32'h0008_1000); wr(ADDR, 32'h0010_1800);
    look(32'h00); chk("evict0_k0", 32'(vld), 0);
    look(32'h20); chk("evict0_k8", 32'(vld), 1); chk("evict0_k8_rs1", 32'(rs1), 2);
    look(32'h40); chk("evict0_k10", 32'(vld), 1); chk("evict0_k10_rs1", 32'(rs1), 3);
    flush();
    wr(ADDR, 32'h0000_0800); wr(ADDR, 32'h0008_1000);
    pc = 32'h0; cyc();
    wr(ADDR, 32'h0010_1800);
    look(32'h00); chk("evict1_k0", 32'(vld), 1); chk("evict1_k0_rs1", 32'(rs1), 1);
    look(32'h20); chk("evict1_k8", 32'(vld), 0);
    look(32'h40); chk("evict1_k10", 32'(vld), 1);
    wr(ADDR + 4, 32'h1);
    look(32'h40); chk("cfg_valid", 32'(vld), 0); chk("cfg_rs1", 32'(rs1), 3);
    wr(ADDR + 4, 32'h0);
    look(32'h0004_0040); chk("hipc_valid", 32'(vld), 0); chk("hipc_rs1", 32'(rs1), 3);
    look(32'h40); chk("cfg_off_valid", 32'(vld), 1);
    wr(ADDR + 8, 32'h0010_0002);
    look(32'h40); chk("inv_valid", 32'(vld), 0); chk("inv_rs1", 32'(rs1), 0);
    look(32'h00); chk("inv_other", 32'(vld), 1);
    wr(ADDR + 8, 32'h1);
    cyc(); cyc();
    RST = 1'b1;
    cyc();
    chk("rst_mid_flush", 32'(bus_if.sasa_busy), 0);
    RST = 1'b0;
`ifdef SPARCE_SASA_STATS_EN
    wr(ADDR, 32'h0010_8845);
    pc = 32'h40; cyc(); cyc();
    wr(ADDR + 4, 32'h1);
    pc = 32'h40; cyc();
    wr(ADDR + 4, 32'h0);
    chk("stat_hits", hits, 3); chk("stat_skips", skips, 2);
    wr(ADDR + 8, 32'h4);
    chk("stat_clr_hits", hits, 0); chk("stat_clr_skips", skips, 0);
`endif
    repeat (3000) begin
      int r;
      logic [15:0] key;
      r = $urandom_range(0, 99);
      key = 16'($urandom_range(0, 31));
      RST = $urandom_range(0, 299) == 0;
      pc = {($urandom_range(0, 9) == 0) ? 14'h1 : 14'h0, 16'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
      bus_if.sasa_enable = r < 30;
      bus_if.sasa_wen = r < 27 || r >= 95;
      bus_if.sasa_addr = r < 15 ? ADDR : r < 19 ? ADDR + 4 : r < 23 ? ADDR + 8 : r < 27 ? ADDR + 12 : ADDR;
      bus_if.sasa_data = {key, 16'($urandom)};
      if (r >= 19 && r < 23) bus_if.sasa_data[0] = $urandom_range(0, 3) == 0;
      cyc();
    end
    RST = 1'b0; bus_if.sasa_enable = 1'b0; bus_if.sasa_wen = 1'b0;
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
